ldst_buffer: RTL and testbench
==============================

# ldst_buffer

In-order load/store buffer sitting directly upstream of the data memory unit. It accepts load/store micro-ops from dispatch and holds them in a circular queue. It captures base-address and store-data operands from the CDB. It issues the oldest entry to memory once it is ready: loads when the base operand is valid, stores additionally when store data is valid and the store is at the ROB head. Issued operations are registered so the memory unit's negedge-clocked array samples stable address, data, enables and ROBEN.

## Interface
- DEPTH, 8: queue entries; power of two, at least 2.
- ROBEN_W, 5: ROB tag width (equals `ROB_SIZE_bits`+1). Tag value 0 means "operand already valid".

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  mispredict flush; empties the queue
- DISP_valid  in  1  dispatch strobe
- DISP_is_store  in  1  1 = store, 0 = load
- DISP_ROBEN  in  ROBEN_W  ROB tag of the op
- DISP_ROBEN1 / DISP_ROBEN1_VAL  in  ROBEN_W / 32  base operand tag / value
- DISP_ROBEN2 / DISP_ROBEN2_VAL  in  ROBEN_W / 32  store-data tag / value (ignored for loads)
- DISP_Immediate  in  32  sign-extended offset
- CDB_valid / CDB_ROBEN / CDB_Result  in  1 / ROBEN_W / 32  result broadcast
- ROB_head_ROBEN  in  ROBEN_W  tag at the ROB head
- LdStB_FULL  out  1  count == DEPTH
- LdStB_MEMU_Read_en / LdStB_MEMU_Write_en  out  1  one-cycle issue pulses, mutually exclusive
- LdStB_MEMU_ROBEN  out  ROBEN_W  tag of the issued op
- LdStB_MEMU_ROBEN1_VAL / LdStB_MEMU_Immediate  out  32  base value and offset of the issued op
- LdStB_MEMU_address  out  32  ROBEN1_VAL + Immediate, modulo 2^32
- LdStB_MEMU_data  out  32  store data; 0 for loads

## Operation
- Storage is a circular queue with head pointer, tail pointer and count (log2(DEPTH)+1 bits). Each entry holds is_store, ROBEN, tag1, val1, tag2, val2 and imm.
- Dispatch: if DISP_valid and not LdStB_FULL, write the entry at tail and increment tail (wrapping at DEPTH). Dispatch while full is dropped; upstream must not do it.
- Operand capture: on CDB_valid, every occupied entry whose tag1 (or tag2) equals CDB_ROBEN and is nonzero loads CDB_Result into val1 (val2) and clears the tag to 0.
  - The same capture applies to a same-cycle dispatch whose DISP_ROBEN1/2 matches the CDB tag.
- Head readiness uses registered entry state only; there is no CDB-to-issue combinational bypass.
  - Load is ready when tag1 == 0.
  - Store is ready when tag1 == 0, tag2 == 0 and ROBEN == ROB_head_ROBEN.
- Issue: if count > 0 and the head is ready, pop the head and register all LdStB_MEMU_* outputs. Assert Read_en (load) or Write_en (store) for exactly one cycle.
  - In cycles without an issue, both enables are 0 and the other outputs hold their last values.
- Only the head may issue. A non-ready head blocks all younger entries, including ready loads.
- Simultaneous dispatch and issue: both take effect and count is unchanged. FULL is based on the registered count, so a dispatch in a full cycle is dropped even if the head issues in that cycle.
- flush or rst: head = tail = count = 0, both enables 0 next cycle. Priority is rst > flush > issue/dispatch/capture.
- Reset values: every output is 0, including LdStB_FULL and LdStB_MEMU_ROBEN.

## Timing
- Dispatch sampled at edge t. The earliest issue is registered at edge t+1, with enables high from t+1 to t+2. The memory unit samples at the negedge inside that window.
- CDB capture at edge t makes the entry eligible for issue at edge t+1.
- Store commit: the ROB head tag must match at edge t for the store to issue at edge t.
- Throughput is at most one issue per cycle. Back-to-back ready heads produce consecutive enable pulses.
- Flush at edge t: any enable pulse registered at t is cleared. No issue occurs at t.
- Pointer wrap: after DEPTH dispatches with no issue, tail returns to the head position and FULL = 1 from the next cycle.

## Test plan
- Reset, then dispatch a load with ROBEN=3, tag1=0, VAL1=100, imm=4 → next cycle Read_en=1, address=104, ROBEN=3, data=0; one pulse only.
- Dispatch a store with ROBEN=5, tag1=0, VAL1=8, imm=0, tag2=2, while ROB_head_ROBEN=5. CDB (2, 0xAB) arrives two cycles later → Write_en pulses the cycle after the CDB, address=8, data=0xAB.
- Dispatch a ready store with ROBEN=6 while the head tag is 4, then a ready load behind it → nothing issues. Set the head tag to 6 → Write_en, then Read_en on the next cycle.
- Dispatch 8 ops with a blocked head → FULL=1. A 9th dispatch is dropped. Unblock → 8 pulses in order, then FULL=0 after the first pop, then count returns to 0.
- Fill 3 entries, then assert flush → enables stay 0. A new load dispatched next issues from the reset pointer state with the correct ROBEN.
- Load with VAL1=0xFFFFFFFF, imm=2 → address=1 (wrap), ROBEN1_VAL and Immediate passed through unchanged.

Source files
------------

// File: rtl/ldst_buffer.sv
// In-order load/store buffer placed directly upstream of the data memory unit.
// Micro-ops from dispatch are held in a circular queue. Their base and store-data
// operands are captured from the CDB. The oldest entry issues once it is ready.
// Issue outputs are registered, so the negedge-clocked memory array samples
// stable values.
module ldst_buffer #(
  parameter int DEPTH   = 8,
  parameter int ROBEN_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               DISP_valid,
  input  logic               DISP_is_store,
  input  logic [ROBEN_W-1:0] DISP_ROBEN,
  input  logic [ROBEN_W-1:0] DISP_ROBEN1,
  input  logic [31:0]        DISP_ROBEN1_VAL,
  input  logic [ROBEN_W-1:0] DISP_ROBEN2,
  input  logic [31:0]        DISP_ROBEN2_VAL,
  input  logic [31:0]        DISP_Immediate,
  input  logic               CDB_valid,
  input  logic [ROBEN_W-1:0] CDB_ROBEN,
  input  logic [31:0]        CDB_Result,
  input  logic [ROBEN_W-1:0] ROB_head_ROBEN,
  output logic               LdStB_FULL,
  output logic               LdStB_MEMU_Read_en,
  output logic               LdStB_MEMU_Write_en,
  output logic [ROBEN_W-1:0] LdStB_MEMU_ROBEN,
  output logic [31:0]        LdStB_MEMU_ROBEN1_VAL,
  output logic [31:0]        LdStB_MEMU_Immediate,
  output logic [31:0]        LdStB_MEMU_address,
  output logic [31:0]        LdStB_MEMU_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // A tag of zero means the matching value field already holds the operand.
  typedef struct packed {
    logic               is_store;
    logic [ROBEN_W-1:0] roben;
    logic [ROBEN_W-1:0] tag1;
    logic [31:0]        val1;
    logic [ROBEN_W-1:0] tag2;
    logic [31:0]        val2;
    logic [31:0]        imm;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [DEPTH-1:0]   occupied;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  entry_t             head_entry;
  entry_t             disp_entry;
  logic               head_ready;
  logic               do_disp;

  // Full is taken from the registered count, so a full cycle drops dispatch even while the head pops.
  assign LdStB_FULL = (count == CNT_W'(DEPTH));
  assign do_disp    = DISP_valid && !LdStB_FULL;

  // Head readiness comes from registered state, and the incoming entry snoops the CDB in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    head_entry = mem[head];
    head_ready = 1'b0;
    disp_entry = '0;

    if (count != '0 && head_entry.tag1 == '0) begin
      head_ready = !head_entry.is_store ||
                   (head_entry.tag2 == '0 && head_entry.roben == ROB_head_ROBEN);
    end

    disp_entry.is_store = DISP_is_store;
    disp_entry.roben    = DISP_ROBEN;
    disp_entry.imm      = DISP_Immediate;
    disp_entry.tag1     = DISP_ROBEN1;
    disp_entry.val1     = DISP_ROBEN1_VAL;
    if (CDB_valid && DISP_ROBEN1 != '0 && DISP_ROBEN1 == CDB_ROBEN) begin
      disp_entry.tag1 = '0;
      disp_entry.val1 = CDB_Result;
    end
    // A load's store-data operand is never consulted, so it is stored as ready.
    if (DISP_is_store) begin
      disp_entry.tag2 = DISP_ROBEN2;
      disp_entry.val2 = DISP_ROBEN2_VAL;
      if (CDB_valid && DISP_ROBEN2 != '0 && DISP_ROBEN2 == CDB_ROBEN) begin
        disp_entry.tag2 = '0;
        disp_entry.val2 = CDB_Result;
      end
    end
  end

  // Entry storage: CDB operand capture on occupied entries, then the dispatch write at the tail.
  always_ff @(posedge clk) begin
    // NOTE: the entry array has no reset. The occupied bits and the pointers decide which entries are live.
    for (int i = 0; i < DEPTH; i++) begin
      if (CDB_valid && occupied[i] && mem[i].tag1 != '0 && mem[i].tag1 == CDB_ROBEN) begin
        mem[i].tag1 <= '0;
        mem[i].val1 <= CDB_Result;
      end
      if (CDB_valid && occupied[i] && mem[i].tag2 != '0 && mem[i].tag2 == CDB_ROBEN) begin
        mem[i].tag2 <= '0;
        mem[i].val2 <= CDB_Result;
      end
    end
    if (do_disp) begin
      mem[tail] <= disp_entry;
    end
  end

  // Queue control and registered issue port, with priority rst > flush > issue/dispatch.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every read sees the pre-edge value.
    if (rst) begin
      head                  <= '0;
      tail                  <= '0;
      count                 <= '0;
      occupied              <= '0;
      LdStB_MEMU_Read_en    <= 1'b0;
      LdStB_MEMU_Write_en   <= 1'b0;
      LdStB_MEMU_ROBEN      <= '0;
      LdStB_MEMU_ROBEN1_VAL <= '0;
      LdStB_MEMU_Immediate  <= '0;
      LdStB_MEMU_address    <= '0;
      LdStB_MEMU_data       <= '0;
    end else if (flush) begin
      head                <= '0;
      tail                <= '0;
      count               <= '0;
      occupied            <= '0;
      LdStB_MEMU_Read_en  <= 1'b0;
      LdStB_MEMU_Write_en <= 1'b0;
    end else begin
      LdStB_MEMU_Read_en  <= 1'b0;
      LdStB_MEMU_Write_en <= 1'b0;
      if (head_ready) begin
        head                  <= head + PTR_W'(1);
        occupied[head]        <= 1'b0;
        LdStB_MEMU_Read_en    <= !head_entry.is_store;
        LdStB_MEMU_Write_en   <= head_entry.is_store;
        LdStB_MEMU_ROBEN      <= head_entry.roben;
        LdStB_MEMU_ROBEN1_VAL <= head_entry.val1;
        LdStB_MEMU_Immediate  <= head_entry.imm;
        LdStB_MEMU_address    <= head_entry.val1 + head_entry.imm;
        LdStB_MEMU_data       <= head_entry.is_store ? head_entry.val2 : 32'd0;
      end
      // head == tail with both active cannot happen: an empty queue never issues and a full one never accepts.
      if (do_disp) begin
        tail           <= tail + PTR_W'(1);
        occupied[tail] <= 1'b1;
      end
      count <= count + CNT_W'(do_disp) - CNT_W'(head_ready);
    end
  end

endmodule

// File: tb/tb_ldst_buffer.sv
// Self-checking bench for ldst_buffer. It runs directed scenarios and then random
// traffic. Every cycle is compared against a queue-based reference model.
module tb_ldst_buffer;

  localparam int DEPTH   = 8;
  localparam int ROBEN_W = 5;

  logic               clk = 1'b0;
  logic               rst, flush;
  logic               DISP_valid, DISP_is_store;
  logic [ROBEN_W-1:0] DISP_ROBEN, DISP_ROBEN1, DISP_ROBEN2;
  logic [31:0]        DISP_ROBEN1_VAL, DISP_ROBEN2_VAL, DISP_Immediate;
  logic               CDB_valid;
  logic [ROBEN_W-1:0] CDB_ROBEN;
  logic [31:0]        CDB_Result;
  logic [ROBEN_W-1:0] ROB_head_ROBEN;
  logic               LdStB_FULL, LdStB_MEMU_Read_en, LdStB_MEMU_Write_en;
  logic [ROBEN_W-1:0] LdStB_MEMU_ROBEN;
  logic [31:0]        LdStB_MEMU_ROBEN1_VAL, LdStB_MEMU_Immediate;
  logic [31:0]        LdStB_MEMU_address, LdStB_MEMU_data;

  ldst_buffer #(.DEPTH(DEPTH), .ROBEN_W(ROBEN_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .DISP_valid(DISP_valid), .DISP_is_store(DISP_is_store), .DISP_ROBEN(DISP_ROBEN),
    .DISP_ROBEN1(DISP_ROBEN1), .DISP_ROBEN1_VAL(DISP_ROBEN1_VAL),
    .DISP_ROBEN2(DISP_ROBEN2), .DISP_ROBEN2_VAL(DISP_ROBEN2_VAL),
    .DISP_Immediate(DISP_Immediate),
    .CDB_valid(CDB_valid), .CDB_ROBEN(CDB_ROBEN), .CDB_Result(CDB_Result),
    .ROB_head_ROBEN(ROB_head_ROBEN),
    .LdStB_FULL(LdStB_FULL),
    .LdStB_MEMU_Read_en(LdStB_MEMU_Read_en), .LdStB_MEMU_Write_en(LdStB_MEMU_Write_en),
    .LdStB_MEMU_ROBEN(LdStB_MEMU_ROBEN), .LdStB_MEMU_ROBEN1_VAL(LdStB_MEMU_ROBEN1_VAL),
    .LdStB_MEMU_Immediate(LdStB_MEMU_Immediate), .LdStB_MEMU_address(LdStB_MEMU_address),
    .LdStB_MEMU_data(LdStB_MEMU_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending ops in program order.
  typedef struct {
    bit        is_store;
    bit [4:0]  roben, tag1, tag2;
    bit [31:0] val1, val2, imm;
  } op_t;

  op_t       q[$];
  bit        m_rd, m_wr, m_full;
  bit [4:0]  m_roben;
  bit [31:0] m_val1, m_imm, m_addr, m_data;

  // Predict the outputs after the next posedge from the inputs applied now.
  task automatic model_step();
    op_t h, n;
    bit  was_full;
    if (rst) begin
      q.delete();
      m_rd = 0; m_wr = 0; m_roben = 0; m_val1 = 0; m_imm = 0; m_addr = 0; m_data = 0;
    end else if (flush) begin
      q.delete();
      m_rd = 0; m_wr = 0;
    end else begin
      was_full = (q.size() == DEPTH);
      m_rd = 0; m_wr = 0;
      if (q.size() > 0) begin
        h = q[0];
        if (h.tag1 == 0 && (!h.is_store || (h.tag2 == 0 && h.roben == ROB_head_ROBEN))) begin
          void'(q.pop_front());
          m_rd    = !h.is_store;
          m_wr    = h.is_store;
          m_roben = h.roben;
          m_val1  = h.val1;
          m_imm   = h.imm;
          m_addr  = h.val1 + h.imm;
          m_data  = h.is_store ? h.val2 : 32'd0;
        end
      end
      if (CDB_valid && CDB_ROBEN != 0) begin
        foreach (q[i]) begin
          if (q[i].tag1 == CDB_ROBEN) begin q[i].tag1 = 0; q[i].val1 = CDB_Result; end
          if (q[i].is_store && q[i].tag2 == CDB_ROBEN) begin q[i].tag2 = 0; q[i].val2 = CDB_Result; end
        end
      end
      if (DISP_valid && !was_full) begin
        n.is_store = DISP_is_store;
        n.roben    = DISP_ROBEN;
        n.tag1     = DISP_ROBEN1;
        n.val1     = DISP_ROBEN1_VAL;
        n.tag2     = DISP_is_store ? DISP_ROBEN2 : 5'd0;
        n.val2     = DISP_ROBEN2_VAL;
        n.imm      = DISP_Immediate;
        if (CDB_valid && CDB_ROBEN != 0) begin
          if (n.tag1 == CDB_ROBEN) begin n.tag1 = 0; n.val1 = CDB_Result; end
          if (n.is_store && n.tag2 == CDB_ROBEN) begin n.tag2 = 0; n.val2 = CDB_Result; end
        end
        q.push_back(n);
      end
    end
    m_full = (q.size() == DEPTH);
  endtask

  task automatic compare_all();
    check("full",  32'(LdStB_FULL),          32'(m_full));
    check("rd_en", 32'(LdStB_MEMU_Read_en),  32'(m_rd));
    check("wr_en", 32'(LdStB_MEMU_Write_en), 32'(m_wr));
    check("roben", 32'(LdStB_MEMU_ROBEN),    32'(m_roben));
    check("val1",  LdStB_MEMU_ROBEN1_VAL,    m_val1);
    check("imm",   LdStB_MEMU_Immediate,     m_imm);
    check("addr",  LdStB_MEMU_address,       m_addr);
    check("data",  LdStB_MEMU_data,          m_data);
  endtask

  // One clock: the model predicts, the edge happens, then outputs are sampled 1ns later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    rst = 0; flush = 0; DISP_valid = 0; DISP_is_store = 0;
    DISP_ROBEN = 0; DISP_ROBEN1 = 0; DISP_ROBEN2 = 0;
    DISP_ROBEN1_VAL = 0; DISP_ROBEN2_VAL = 0; DISP_Immediate = 0;
    CDB_valid = 0; CDB_ROBEN = 0; CDB_Result = 0;
  endtask

  task automatic disp(input bit st, input bit [4:0] rob, input bit [4:0] t1, input bit [31:0] v1,
                      input bit [4:0] t2, input bit [31:0] v2, input bit [31:0] im);
    DISP_valid = 1; DISP_is_store = st; DISP_ROBEN = rob;
    DISP_ROBEN1 = t1; DISP_ROBEN1_VAL = v1;
    DISP_ROBEN2 = t2; DISP_ROBEN2_VAL = v2; DISP_Immediate = im;
  endtask

  initial begin
    idle();
    ROB_head_ROBEN = 0;
    rst = 1;
    tick(); tick();
    check("rst_full", 32'(LdStB_FULL), 32'd0);
    check("rst_roben", 32'(LdStB_MEMU_ROBEN), 32'd0);
    rst = 0;

    // Ready load issues one cycle after dispatch as a single pulse.
    disp(0, 5'd3, 5'd0, 32'd100, 5'd0, 32'd0, 32'd4);
    tick(); idle();
    check("t1_no_early", 32'(LdStB_MEMU_Read_en), 32'd0);
    tick();
    check("t1_rd", 32'(LdStB_MEMU_Read_en), 32'd1);
    check("t1_addr", LdStB_MEMU_address, 32'd104);
    check("t1_roben", 32'(LdStB_MEMU_ROBEN), 32'd3);
    check("t1_data", LdStB_MEMU_data, 32'd0);
    tick();
    check("t1_one_pulse", 32'(LdStB_MEMU_Read_en), 32'd0);

    // Store waits for its data from the CDB, then issues the next cycle.
    ROB_head_ROBEN = 5;
    disp(1, 5'd5, 5'd0, 32'd8, 5'd2, 32'd0, 32'd0);
    tick(); idle();
    tick();
    CDB_valid = 1; CDB_ROBEN = 2; CDB_Result = 32'hAB;
    tick(); idle();
    check("t2_wait", 32'(LdStB_MEMU_Write_en), 32'd0);
    tick();
    check("t2_wr", 32'(LdStB_MEMU_Write_en), 32'd1);
    check("t2_addr", LdStB_MEMU_address, 32'd8);
    check("t2_data", LdStB_MEMU_data, 32'hAB);

    // A store that is not at the ROB head blocks a ready load behind it.
    ROB_head_ROBEN = 4;
    disp(1, 5'd6, 5'd0, 32'd16, 5'd0, 32'd7, 32'd0);
    tick();
    disp(0, 5'd7, 5'd0, 32'd32, 5'd0, 32'd0, 32'd0);
    tick(); idle();
    tick(); tick();
    check("t3_blocked", 32'(LdStB_MEMU_Read_en | LdStB_MEMU_Write_en), 32'd0);
    ROB_head_ROBEN = 6;
    tick();
    check("t3_wr", 32'(LdStB_MEMU_Write_en), 32'd1);
    tick();
    check("t3_rd", 32'(LdStB_MEMU_Read_en), 32'd1);
    check("t3_rd_roben", 32'(LdStB_MEMU_ROBEN), 32'd7);

    // Fill to FULL behind a blocked store, drop a 9th op, then drain in order.
    ROB_head_ROBEN = 0;
    disp(1, 5'd9, 5'd0, 32'd1, 5'd0, 32'd2, 32'd3);
    tick();
    for (int k = 0; k < DEPTH - 1; k++) begin
      disp(0, 5'(10 + k), 5'd0, 32'(k), 5'd0, 32'd0, 32'd0);
      tick();
    end
    check("t4_full", 32'(LdStB_FULL), 32'd1);
    disp(0, 5'd30, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    tick(); idle();
    check("t4_still_full", 32'(LdStB_FULL), 32'd1);
    ROB_head_ROBEN = 9;
    tick();
    check("t4_wr", 32'(LdStB_MEMU_Write_en), 32'd1);
    check("t4_not_full", 32'(LdStB_FULL), 32'd0);
    for (int k = 0; k < DEPTH - 1; k++) begin
      tick();
      check("t4_drain_roben", 32'(LdStB_MEMU_ROBEN), 32'(10 + k));
    end
    tick();
    check("t4_empty", 32'(LdStB_MEMU_Read_en), 32'd0);

    // Flush discards queued ops, and the next load issues normally.
    ROB_head_ROBEN = 0;
    disp(1, 5'd20, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    tick();
    disp(0, 5'd21, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    tick(); tick(); idle();
    flush = 1;
    tick(); idle();
    check("t5_flush_en", 32'(LdStB_MEMU_Read_en | LdStB_MEMU_Write_en), 32'd0);
    disp(0, 5'd22, 5'd0, 32'd50, 5'd0, 32'd0, 32'd1);
    tick(); idle();
    tick();
    check("t5_rd", 32'(LdStB_MEMU_Read_en), 32'd1);
    check("t5_roben", 32'(LdStB_MEMU_ROBEN), 32'd22);

    // Address arithmetic wraps modulo 2^32.
    disp(0, 5'd1, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'd2);
    tick(); idle();
    tick();
    check("t6_addr", LdStB_MEMU_address, 32'd1);
    check("t6_val1", LdStB_MEMU_ROBEN1_VAL, 32'hFFFF_FFFF);
    check("t6_imm", LdStB_MEMU_Immediate, 32'd2);

    // Random traffic. Small tag ranges make CDB hits and ROB-head matches frequent.
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 1)
        disp($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 7)), $urandom(),
             5'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 7)), $urandom(), $urandom());
      if ($urandom_range(0, 1) == 1) begin
        CDB_valid = 1; CDB_ROBEN = 5'($urandom_range(0, 7)); CDB_Result = $urandom();
      end
      if ($urandom_range(0, 3) == 0) ROB_head_ROBEN = 5'($urandom_range(0, 7));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
